// File: rtl/muacm_tx_framer.sv
// Byte-stream framer feeding the muacm IN pipe.
// FWFT FIFO with packet tagging and idle flush generation.
module muacm_tx_framer #(
    parameter int          LOG2_DEPTH = 4,
    parameter int          MAX_PKT    = 64,
    parameter bit          DELIM_EN   = 1'b1,
    parameter logic [7:0]  DELIM      = 8'h0a,
    parameter int          TIMEOUT    = 4800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [7:0]            in_data,
    output logic                  in_last,
    output logic                  in_valid,
    input  logic                  in_ready,
    output logic                  in_flush_now,
    output logic                  in_flush_time,
    output logic [LOG2_DEPTH:0]   level
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int LW    = LOG2_DEPTH + 1;
    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [6:0]    WMAX = 7'(MAX_PKT - 1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH-1:0]      lmem;
    logic [LOG2_DEPTH-1:0] wptr;
    logic [LOG2_DEPTH-1:0] rptr;
    logic [LW-1:0]         lvl;
    logic [6:0]            wcnt;
    logic [TW-1:0]         idle;
    logic                  run;
    logic                  pend;
    logic                  flush_q;

    logic full, empty, wr, rd, wlast, idle_on, fire;

    assign full    = (lvl == LW'(DEPTH));
    assign empty   = (lvl == '0);
    assign s_ready = run && !full;
    assign wr      = s_valid && s_ready;
    assign in_valid = !empty;
    assign rd      = in_valid && in_ready;
    assign in_data = empty ? 8'h00 : mem[rptr];
    assign in_last = !empty && lmem[rptr];
    assign wlast   = (DELIM_EN && (s_data == DELIM)) || (wcnt == WMAX);

    // Idle timer only runs while a packet is left open with nothing queued
    assign idle_on = (TIMEOUT != 0) && empty && pend;
    assign fire    = idle_on && !wr && (idle == TMAX);

    assign in_flush_now  = flush_q;
    assign in_flush_time = empty;
    assign level         = lvl;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            lmem    <= '0;
            wptr    <= '0;
            rptr    <= '0;
            lvl     <= '0;
            wcnt    <= '0;
            idle    <= '0;
            pend    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            run <= 1'b1;
            if (wr) begin
                wptr       <= wptr + 1'b1;
                lmem[wptr] <= wlast;
                wcnt       <= wlast ? 7'd0 : wcnt + 7'd1;
            end
            if (rd) begin
                rptr <= rptr + 1'b1;
            end
            if (wr && !rd) begin
                lvl <= lvl + 1'b1;
            end else if (rd && !wr) begin
                lvl <= lvl - 1'b1;
            end
            flush_q <= fire;
            if (fire || !idle_on || wr) begin
                idle <= '0;
            end else begin
                idle <= idle + 1'b1;
            end
            if (TIMEOUT == 0) begin
                pend <= 1'b0;
            end else if (rd) begin
                pend <= !in_last;
            end else if (fire) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: doc/muacm_tx_framer.md
Name: muacm_tx_framer

Overview:
- Sits directly upstream of the muacm IN pipe (device-to-host direction).
- Accepts a raw byte stream from user logic and buffers it in a small FIFO.
- Tags packet boundaries (in_last) on a delimiter byte or at a maximum packet length.
- Drives in_flush_now / in_flush_time so short trailing data reaches the host without waiting for a full packet.

Parameters:
- LOG2_DEPTH, 4, FIFO depth = 2^LOG2_DEPTH entries (each entry 8 data bits + 1 last flag); legal range 1..8.
- MAX_PKT, 64, maximum bytes per packet before a forced in_last; legal range 1..64.
- DELIM_EN, 1, when 1, a byte equal to DELIM closes the packet.
- DELIM, 8'h0a, delimiter byte value.
- TIMEOUT, 4800, idle cycles before a forced flush pulse; 0 disables forced flush.

Ports:
- clk  in  1  system clock (the muacm clock domain).
- rst_n  in  1  reset: asynchronous assert, active-low.
- s_data  in  8  upstream byte.
- s_valid  in  1  upstream byte valid.
- s_ready  out  1  framer can accept a byte.
- in_data  out  8  byte to muacm.
- in_last  out  1  byte closes a packet.
- in_valid  out  1  in_data valid.
- in_ready  in  1  muacm accepts the byte.
- in_flush_now  out  1  single-cycle forced-flush request.
- in_flush_time  out  1  timed flush permitted.
- level  out  LOG2_DEPTH+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous) values:
  - s_ready=0, in_valid=0, in_last=0, in_data=0, in_flush_now=0, in_flush_time=1, level=0.
  - All pointers and counters are cleared; FIFO contents are discarded.
- Release from reset: s_ready rises on the first clk edge after rst_n goes high.
- Write: occurs when s_valid && s_ready. s_ready = !full.
  - There is no write-through when full, even if a read happens in the same cycle.
- Read: occurs when in_valid && in_ready. in_valid = !empty; the FIFO is first-word-fall-through.
- Latency: a byte written on edge N is presented at in_valid/in_data after edge N, i.e. one cycle. No bubbles while data is buffered; sustained throughput is 1 byte/cycle.
- Simultaneous read and write: level is unchanged. Pointers wrap modulo 2^LOG2_DEPTH.
- Level arithmetic: level counts 0..2^LOG2_DEPTH inclusive.
  - full = (level == 2^LOG2_DEPTH); empty = (level == 0).
- Last-flag computation (at write time, stored per entry):
  - last = (DELIM_EN && s_data==DELIM) || (wcnt == MAX_PKT-1).
  - wcnt counts bytes written in the current packet. It clears on a write whose last=1 and increments otherwise.
- in_last is the stored flag of the head entry. It is qualified by in_valid and is 0 whenever the FIFO is empty.
- in_flush_time = empty: muacm may flush on its own timer only when nothing else is queued.
- Pending flag pend:
  - Set on a read with in_last=0.
  - Cleared on a read with in_last=1, or when in_flush_now fires.
  - Read wins over set if both occur in the same cycle.
- Idle counter:
  - Increments each cycle while empty && pend && TIMEOUT!=0.
  - Clears on any write, and whenever that condition is false.
  - When the counter reaches TIMEOUT-1, in_flush_now is 1 for exactly one cycle, then pend and the counter clear.
  - A write in the same cycle suppresses the pulse.
- TIMEOUT=0: in_flush_now is tied to 0 and pend is ignored.
- MAX_PKT=1: every byte carries last=1.
- A delimiter arriving at byte count MAX_PKT-1 produces a single last flag and a single wcnt clear.
- in_data and in_last hold stable while in_valid && !in_ready.

Test Plan:
- Reset then write 0x41,0x42,0x0a with in_ready=1 -> in_valid first seen one cycle after the first write; bytes emerge in order; in_last=1 only on 0x0a; level returns to 0.
- DELIM_EN=0, MAX_PKT=4, write 10 bytes 0x00..0x09 -> in_last=1 on 0x03 and 0x07 only; 0x08 and 0x09 follow with in_last=0.
- LOG2_DEPTH=2, in_ready=0, drive s_valid for 6 cycles -> exactly 4 bytes accepted; s_ready=0 and level=4; raising in_ready drains 0..3 in order and s_ready re-asserts the cycle after the first read.
- TIMEOUT=8: send 0x31 (no delimiter), drain it, then idle -> in_flush_now pulses exactly once, 8 cycles after the FIFO goes empty; no further pulse while idle. Repeat with a new write at idle cycle 5 -> no pulse.
- Full with simultaneous read and s_valid -> no write that cycle; level drops by 1; the next cycle accepts the write.
- Assert rst_n low mid-packet with level=3 and pend=1 -> outputs take reset values immediately (asynchronously); after release, the first written byte starts a fresh packet (wcnt=0) and no stale flush occurs.
